// File: rtl/bcd2bin.sv
// rtl/bcd2bin.sv - packed BCD to binary converter, iterative reverse double-dabble
module bcd2bin #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   bcd,
  input  logic                  bcd_vld,
  output logic                  bcd_rdy,
  output logic [BIN_W-1:0]      bin,
  output logic                  bin_vld,
  output logic                  err
);

  localparam int W     = 4 * DIGITS;
  localparam int CNT_W = (W > 2) ? $clog2(W) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(W - 1);

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t state;
  state_t next_state;

  // Work register: the BCD digits drain out of dig into acc one bit per step.
  logic [W-1:0]     dig;
  logic [W-1:0]     acc;
  logic [CNT_W-1:0] cnt;
  logic             inv;

  logic [W-1:0]     next_dig;
  logic [W-1:0]     next_acc;
  logic [2*W-1:0]   shifted;
  logic             in_inv;
  logic             accept;
  logic             last_step;
  logic             ovf;

  assign accept    = bcd_vld & bcd_rdy;
  assign last_step = (state == CONV) && (cnt == LAST_STEP);

  // One reverse double-dabble step: shift right, then pull every digit >= 8 down by 3.
  always_comb begin
    shifted  = {dig, acc} >> 1;
    next_dig = shifted[2*W-1:W];
    next_acc = shifted[W-1:0];
    for (int i = 0; i < DIGITS; i++) begin
      if (next_dig[4*i +: 4] >= 4'd8) begin
        next_dig[4*i +: 4] = next_dig[4*i +: 4] - 4'd3;
      end
    end
  end

  // Flag any non-decimal nibble on the incoming word so it can be reported at the end.
  always_comb begin
    in_inv = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] > 4'd9) begin
        in_inv = 1'b1;
      end
    end
  end

  // Overflow when any bit above the output width is set in the final value.
  always_comb begin
    ovf = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (i >= BIN_W && next_acc[i]) begin
        ovf = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: one conversion runs for exactly W steps.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept)    next_state = CONV;
      CONV:    if (last_step) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode: ready whenever no conversion is in flight.
  always_comb begin
    bcd_rdy = 1'b0;
    case (state)
      IDLE:    bcd_rdy = 1'b1;
      default: bcd_rdy = 1'b0;
    endcase
  end

  // Datapath: load on accept, step while converting, publish result on the last step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig     <= '0;
      acc     <= '0;
      cnt     <= '0;
      inv     <= 1'b0;
      bin     <= '0;
      err     <= 1'b0;
      bin_vld <= 1'b0;
    end else begin
      bin_vld <= 1'b0;
      if (accept) begin
        dig <= bcd;
        acc <= '0;
        cnt <= '0;
        inv <= in_inv;
      end else if (state == CONV) begin
        dig <= next_dig;
        acc <= next_acc;
        cnt <= cnt + 1'b1;
        if (last_step) begin
          bin_vld <= 1'b1;
          // A bad digit makes the value meaningless, so it takes priority over saturation.
          if (inv) begin
            bin <= '0;
            err <= 1'b1;
          end else if (ovf) begin
            bin <= '1;
            err <= 1'b1;
          end else begin
            bin <= next_acc[BIN_W-1:0];
            err <= 1'b0;
          end
        end
      end
    end
  end

endmodule
